// File: rtl/serial_adder_n_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
// Imported by both the top level and the full-adder slice.
package serial_adder_n_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of digit steps needed to cover the full operand width.
    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

    // Counter width: clog2 of the step count, never narrower than one bit.
    function automatic int cnt_width(input int width, input int digit);
        int n;
        n = width / digit;
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_adder_n_fa_slice.sv
// DIGIT-bit combinational ripple full adder.
// Also exposes the carry into its top bit, which the parent uses for signed overflow.
module fa_slice
    import serial_adder_n_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]     = x[i] ^ y[i] ^ c[i];
            c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign co    = c[DIGIT];
    assign c_msb = c[DIGIT - 1];

endmodule

// File: rtl/serial_adder_n.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed LSB-first, DIGIT bits
// per cycle through one fa_slice, with a start/busy/done handshake.
module serial_adder_n
    import serial_adder_n_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = num_digits(WIDTH, DIGIT);
    localparam int CW = cnt_width(WIDTH, DIGIT);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] slice_s;
    logic             slice_co;
    logic             slice_c_msb;
    logic             accept;
    logic             last_digit;

    fa_slice #(
        .DIGIT(DIGIT)
    ) u_slice (
        .x     (op_a[DIGIT-1:0]),
        .y     (op_b[DIGIT-1:0]),
        .ci    (carry),
        .s     (slice_s),
        .co    (slice_co),
        .c_msb (slice_c_msb)
    );

    // New digits enter at the top so the LSB digit ends up at bit 0 after N steps.
    generate
        if (DIGIT == WIDTH) begin : g_one_step
            assign acc_next = slice_s;
        end else begin : g_shift
            assign acc_next = {slice_s, acc[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_digit = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(N - 1)) begin
                    last_digit = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                accept     = start;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Subtraction is a + ~b + ~cin; the inverted borrow-in supplies the +1.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? ~cin : cin;
            cnt   <= '0;
            acc   <= '0;
        end else if (state == RUN) begin
            op_a  <= op_a >> DIGIT;
            op_b  <= op_b >> DIGIT;
            carry <= slice_co;
            cnt   <= cnt + CW'(1);
            acc   <= acc_next;
            if (last_digit) begin
                sum  <= acc_next;
                cout <= slice_co;
                ovf  <= slice_co ^ slice_c_msb;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_n.sv
// Bench for serial_adder_n: three instances (8/1, 8/4, 3/1) sharing clock and reset,
// with a result queue checked whenever a done pulse appears.
module tb_serial_adder_n;

    typedef struct {
        int         dut;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         due;
    } exp_t;

    typedef struct {
        int         k;
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;
    exp_t sbq[$];

    logic       st0 = 0, sb0 = 0, ci0 = 0, busy0, done0, co0, ov0;
    logic [7:0] a0 = '0, b0 = '0, sum0;
    logic       st1 = 0, sb1 = 0, ci1 = 0, busy1, done1, co1, ov1;
    logic [7:0] a1 = '0, b1 = '0, sum1;
    logic       st2 = 0, sb2 = 0, ci2 = 0, busy2, done2, co2, ov2;
    logic [2:0] a2 = '0, b2 = '0, sum2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder_n #(.WIDTH(8), .DIGIT(1)) u_d0 (
        .clk(clk), .rst(rst), .start(st0), .sub(sb0), .a(a0), .b(b0), .cin(ci0),
        .busy(busy0), .done(done0), .sum(sum0), .cout(co0), .ovf(ov0));
    serial_adder_n #(.WIDTH(8), .DIGIT(4)) u_d1 (
        .clk(clk), .rst(rst), .start(st1), .sub(sb1), .a(a1), .b(b1), .cin(ci1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(co1), .ovf(ov1));
    serial_adder_n #(.WIDTH(3), .DIGIT(1)) u_d2 (
        .clk(clk), .rst(rst), .start(st2), .sub(sb2), .a(a2), .b(b2), .cin(ci2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(co2), .ovf(ov2));

    function automatic int nd(input int k);
        return (k == 0) ? 8 : (k == 1) ? 2 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Independent reference: signed/unsigned integer arithmetic on WIDTH-bit values.
    function automatic exp_t model(input int w, input int a, input int b,
                                   input logic sub, input logic cin);
        exp_t e;
        int m, sa, sb, u, r;
        m  = 1 << w;
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        if (sub) begin
            u      = a - b - int'(cin);
            r      = sa - sb - int'(cin);
            e.cout = (u >= 0);
        end else begin
            u      = a + b + int'(cin);
            r      = sa + sb + int'(cin);
            e.cout = (u >= m);
        end
        e.sum = 8'(u & (m - 1));
        e.ovf = (r >= m / 2) || (r < -(m / 2));
        e.dut = 2;
        e.due = 0;
        return e;
    endfunction

    task automatic check_done(input int k, input logic [7:0] s, input logic c, input logic o);
        exp_t e;
        if (sbq.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL unexpected_done: dut %0d pulsed done, required no done (cycle %0d)", k, cyc);
        end else begin
            e = sbq.pop_front();
            chk("done_dut", k, e.dut);
            chk("sum", s, e.sum);
            chk("cout", c, e.cout);
            chk("ovf", o, e.ovf);
            chk("latency", cyc, e.due);
        end
    endtask

    always @(negedge clk) begin
        if (done0 === 1'b1) check_done(0, sum0, co0, ov0);
        if (done1 === 1'b1) check_done(1, sum1, co1, ov1);
        if (done2 === 1'b1) check_done(2, {5'b0, sum2}, co2, ov2);
    end

    // Called at a negedge; the start is accepted at the following posedge.
    task automatic issue(input int k, input logic [7:0] a, input logic [7:0] b,
                         input logic sub, input logic cin, input logic push,
                         input logic [7:0] esum, input logic ecout, input logic eovf);
        exp_t e;
        case (k)
            0:       begin a0 = a; b0 = b; sb0 = sub; ci0 = cin; st0 = 1'b1; end
            1:       begin a1 = a; b1 = b; sb1 = sub; ci1 = cin; st1 = 1'b1; end
            default: begin a2 = a[2:0]; b2 = b[2:0]; sb2 = sub; ci2 = cin; st2 = 1'b1; end
        endcase
        if (push) begin
            e.dut  = k;
            e.sum  = esum;
            e.cout = ecout;
            e.ovf  = eovf;
            e.due  = cyc + 1 + nd(k);
            sbq.push_back(e);
        end
        @(negedge clk);
        st0 = 1'b0;
        st1 = 1'b0;
        st2 = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        int i;
        i = 0;
        while (sbq.size() != 0 && i < max) begin
            @(negedge clk);
            i++;
        end
        if (sbq.size() != 0) begin
            nchk++;
            nerr++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    function automatic logic [7:0] cur_sum(input int k);
        return (k == 0) ? sum0 : (k == 1) ? sum1 : {5'b0, sum2};
    endfunction

    vec_t       vecs[9];
    logic [7:0] hold0;
    exp_t       em;
    int         got;
    int         ndone;

    initial begin
        vecs[0] = '{0, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{0, 8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0};
        vecs[3] = '{0, 8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{1, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[5] = '{1, 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[6] = '{1, 8'hFF, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{1, 8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[8] = '{0, 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
        hold0 = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_sum", sum0, 0);
        chk("rst_cout", co0, 0);
        chk("rst_ovf", ov0, 0);
        chk("rst_sum_d1", sum1, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].k, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, 1'b1,
                  vecs[i].sum, vecs[i].cout, vecs[i].ovf);
            wait_drain(nd(vecs[i].k) + 6);
            repeat (2) @(negedge clk);
            chk("hold_idle", cur_sum(vecs[i].k), vecs[i].sum);
            if (vecs[i].k == 0) hold0 = vecs[i].sum;
        end

        // Mid-RUN start must be ignored and the old sum held while running.
        issue(0, 8'h33, 8'h11, 1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0);
        chk("run_busy", busy0, 1);
        chk("hold_in_run", sum0, hold0);
        repeat (2) @(negedge clk);
        a0 = 8'hAA; b0 = 8'hAA; st0 = 1'b1;
        @(negedge clk);
        st0 = 1'b0;
        chk("hold_in_run_late", sum0, hold0);
        wait_drain(16);
        repeat (5) @(negedge clk);
        chk("ignored_start_sum", sum0, 8'h44);
        chk("ignored_start_idle", busy0, 0);

        // Start in the DONE cycle re-enters RUN without an idle cycle.
        issue(1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 8'h46, 1'b0, 1'b0);
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            @(negedge clk);
            if (done1) got = 1;
        end
        chk("b2b_first_done", got, 1);
        issue(1, 8'h70, 8'h70, 1'b0, 1'b0, 1'b1, 8'hE0, 1'b0, 1'b1);
        chk("b2b_busy", busy1, 1);
        chk("b2b_done_fell", done1, 0);
        wait_drain(10);

        // Reset in the third RUN cycle discards the operation.
        issue(0, 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy0, 0);
        chk("midrst_done", done0, 0);
        chk("midrst_sum", sum0, 0);
        chk("midrst_cout", co0, 0);
        chk("midrst_ovf", ov0, 0);
        rst = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done0) ndone++;
        end
        chk("midrst_no_done", ndone, 0);
        issue(0, 8'h01, 8'h01, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
        wait_drain(16);
        chk("after_rst_sum", sum0, 8'h02);

        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
                for (int s = 0; s < 2; s++)
                    for (int c = 0; c < 2; c++) begin
                        em = model(3, a, b, 1'(s), 1'(c));
                        issue(2, 8'(a), 8'(b), 1'(s), 1'(c), 1'b1, em.sum, em.cout, em.ovf);
                        wait_drain(10);
                    end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", nchk, nerr);
        $fatal(1, "watchdog expired");
    end

endmodule
